// File: rtl/round_key_sequencer_pkg.sv
// Shared widths and FSM encoding for the round-key sequencer and the logic around it.
package round_key_sequencer_pkg;

  localparam int KEY_W   = 128;
  localparam int ADDR_W  = 4;
  localparam int ROUND_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/round_key_sequencer.sv
// Walks a key ROM forwards or backwards and hands round keys to the cipher datapath
// under a valid/ready handshake. The key ROM is outside; Address is its combinational read index.
module round_key_sequencer
  import round_key_sequencer_pkg::*;
#(
  parameter int NUM_ROUNDS = 10,
  parameter int KEY_BASE   = 0
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               Start,
  input  logic               Decrypt,
  input  logic               Abort,
  input  logic               Ready,
  output logic [ADDR_W-1:0]  Address,
  input  logic [KEY_W-1:0]   Data,
  output logic [KEY_W-1:0]   RoundKey,
  output logic [ROUND_W-1:0] Round,
  output logic               KeyValid,
  output logic               LastRound,
  output logic               Busy,
  output logic               Done
);

  if (KEY_BASE < 0 || NUM_ROUNDS < 0 || KEY_BASE + NUM_ROUNDS > 15) begin : g_bad_params
    $error("round_key_sequencer: KEY_BASE + NUM_ROUNDS must lie within 0..15");
  end

  localparam logic [ADDR_W-1:0]  FIRST_ASC  = ADDR_W'(KEY_BASE);
  localparam logic [ADDR_W-1:0]  FIRST_DESC = ADDR_W'(KEY_BASE + NUM_ROUNDS);
  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS);

  state_t               r_state;
  state_t               w_next_state;
  logic [ADDR_W-1:0]    r_addr;
  logic                 r_decrypt;
  logic [KEY_W-1:0]     r_round_key;
  logic [ROUND_W-1:0]   r_round;
  logic [ADDR_W:0]      w_addr_ext;
  logic [ROUND_W-1:0]   w_new_round;
  logic                 w_accept;
  logic                 w_abort;
  logic                 w_load;
  logic                 w_step;

  assign w_accept    = (r_state == IDLE) && Start && !Abort;
  assign w_abort     = (r_state != IDLE) && Abort;
  assign w_load      = (r_state == FETCH) ||
                       ((r_state == PRESENT) && Ready && (r_round != LAST_ROUND));
  assign w_new_round = (r_state == FETCH) ? '0 : r_round + 1'b1;
  // One extra bit so a step past 0 or 15 is visible and can be refused.
  assign w_addr_ext  = r_decrypt ? {1'b0, r_addr} - 1'b1 : {1'b0, r_addr} + 1'b1;
  assign w_step      = (w_new_round < LAST_ROUND) && !w_addr_ext[ADDR_W];

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: default assignment first so no path through the case leaves w_next_state unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = FETCH;
      FETCH:   w_next_state = Abort ? IDLE : PRESENT;
      PRESENT: begin
        if (Abort)                               w_next_state = IDLE;
        else if (Ready && r_round == LAST_ROUND) w_next_state = DONE;
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    KeyValid  = (r_state == PRESENT);
    Busy      = (r_state != IDLE);
    Done      = (r_state == DONE);
    LastRound = (r_state == PRESENT) && (r_round == LAST_ROUND);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_addr      <= FIRST_ASC;
      r_decrypt   <= 1'b0;
      r_round_key <= '0;
      r_round     <= '0;
    end else if (w_abort || r_state == DONE) begin
      r_addr <= FIRST_ASC;
    end else if (w_accept) begin
      r_decrypt <= Decrypt;
      r_addr    <= Decrypt ? FIRST_DESC : FIRST_ASC;
    end else if (w_load) begin
      r_round_key <= Data;
      r_round     <= w_new_round;
      if (w_step) r_addr <= w_addr_ext[ADDR_W-1:0];
    end
  end

  assign Address  = r_addr;
  assign RoundKey = r_round_key;
  assign Round    = r_round;

endmodule

// File: doc/round_key_sequencer.md
ROUND_KEY_SEQUENCER -- requirements
Module: round_key_sequencer

Interface
REQ-001 Parameter: NUM_ROUNDS, 10, index of last key; keys KEY_BASE..KEY_BASE+NUM_ROUNDS are delivered.
REQ-002 Parameter: KEY_BASE, 0, key-ROM index of round key 0; KEY_BASE+NUM_ROUNDS SHALL be <= 15 (elaboration error otherwise).
REQ-003 Port: Clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: Rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port: Start  in  1  begin a key sequence; accepted only in IDLE.
REQ-006 Port: Decrypt  in  1  direction, sampled with accepted Start: 0 = ascending, 1 = descending.
REQ-007 Port: Abort  in  1  synchronous cancel of the current sequence.
REQ-008 Port: Ready  in  1  cipher datapath accepts RoundKey this cycle.
REQ-009 Port: Address  out  4  key-ROM index, combinational read.
REQ-010 Port: Data  in  128  key-ROM read data for Address.
REQ-011 Port: RoundKey  out  128  registered round key to the datapath.
REQ-012 Port: Round  out  4  transfer ordinal 0..NUM_ROUNDS, regardless of direction.
REQ-013 Port: KeyValid  out  1  RoundKey/Round valid.
REQ-014 Port: LastRound  out  1  KeyValid && Round == NUM_ROUNDS.
REQ-015 Port: Busy  out  1  high in every state except IDLE.
REQ-016 Port: Done  out  1  one-cycle pulse after the final transfer.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, PRESENT, DONE.
REQ-018 IDLE: Start=1 and Abort=0 -> FETCH; Address loads first index (KEY_BASE ascending, KEY_BASE+NUM_ROUNDS descending); Decrypt latched.
REQ-019 FETCH: RoundKey <= Data, Round <= 0, Address steps to the next index, -> PRESENT (KeyValid=1 next cycle); Start-to-first-KeyValid latency SHALL be 2 cycles.
REQ-020 Transfer SHALL occur when KeyValid && Ready; without transfer RoundKey, Round, Address SHALL hold.
REQ-021 PRESENT transfer with Round < NUM_ROUNDS: RoundKey <= Data, Round <= Round+1, Address steps; Ready held high yields one key per cycle, no bubbles.
REQ-022 PRESENT transfer with Round == NUM_ROUNDS: -> DONE, KeyValid <= 0; Address not stepped past the end index.
REQ-023 DONE: Done=1 for exactly one cycle, -> IDLE; Start in DONE SHALL be ignored.
REQ-024 Address arithmetic SHALL be 5-bit internally; no wrap below 0 or above 15 is ever issued.
REQ-025 Abort in any non-IDLE state: -> IDLE next cycle, KeyValid=0, Done not pulsed; Abort beats Start and Ready in the same cycle.
REQ-026 Start while Busy and Decrypt changes outside accepted Start SHALL have no effect.
REQ-027 IDLE outputs: KeyValid=0, Done=0, Busy=0, Address=KEY_BASE, RoundKey holds last value.

Reset
REQ-028 Rst_n=0 SHALL immediately force IDLE, Address=KEY_BASE, RoundKey=0, Round=0, KeyValid=0, Done=0, Busy=0, including mid-sequence.
REQ-029 First Start SHALL be accepted on the first rising edge with Rst_n=1.

Structure
REQ-030 Shared package SHALL hold KEY_W=128, ADDR_W=4, and the FSM state typedef/encoding.
REQ-031 No sub-module inside; the parent instantiates the key ROM (memory) alongside and connects Address/Data.

Verification
REQ-032 Ascending, Ready=1: Start at cycle 0 -> KeyValid cycles 2..12, RoundKey cycle 2 = 54776F204F6E65204E696E652054776F, cycle 12 = 1D6DBBABCFB7988D8EF912F76883CDC1 with LastRound=1, Done at cycle 13.
REQ-033 Decrypt=1, Ready=1: first RoundKey = 1D6DBBABCFB7988D8EF912F76883CDC1 with Round=0; last = 54776F20...776F with Round=10.
REQ-034 Ready low 3 cycles at Round=4 (ascending) -> RoundKey holds AD3505D474AA1052A26CC4E51C272B5B, Round=4, 14 total cycles of KeyValid.
REQ-035 Abort at Round=6 -> next cycle IDLE, KeyValid=0, Busy=0, no Done; new Start gives Round=0 key again.
REQ-036 Rst_n low at Round=3 -> outputs zero immediately; Start during Busy and in DONE ignored (no restart, single Done).
